// File: rtl/decoder_3_to_8_bh.sv
// Registered 3-to-8 decoder with enable and selectable output polarity.
// Each output line is its own cell so the register can never hold a multi-hot code.

module decoder_3_to_8_bh_bit #(
  parameter int unsigned IDX            = 0,
  parameter bit          OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] a_i,
  input  logic       e_i,
  output logic       y_o
);
  logic y_d, y_q;

  // An unknown code with e low falls through to the inactive level.
  always_comb begin
    y_d = OUT_ACTIVE_LOW;
    if (e_i && (a_i == 3'(IDX))) y_d = ~OUT_ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (rst) y_q <= OUT_ACTIVE_LOW;
    else     y_q <= y_d;
  end

  assign y_o = y_q;
endmodule

module decoder_3_to_8_bh #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] a,
  input  logic       e,
  output logic [7:0] y,
  output logic       y_valid
);
  logic y_valid_q;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    decoder_3_to_8_bh_bit #(
      .IDX            (i),
      .OUT_ACTIVE_LOW (OUT_ACTIVE_LOW)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .a_i (a),
      .e_i (e),
      .y_o (y[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) y_valid_q <= 1'b0;
    else     y_valid_q <= e;
  end

  assign y_valid = y_valid_q;
endmodule

// File: tb/tb_decoder_3_to_8_bh.sv
// Directed bench for decoder_3_to_8_bh: one active-high and one active-low instance
// share the same stimulus.

module tb_decoder_3_to_8_bh;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] a   = 3'b000;
  logic       e   = 1'b0;
  logic [7:0] y_h, y_l;
  logic       v_h, v_l;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  decoder_3_to_8_bh #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst(rst), .a(a), .e(e), .y(y_h), .y_valid(v_h)
  );
  decoder_3_to_8_bh #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst(rst), .a(a), .e(e), .y(y_l), .y_valid(v_l)
  );

  // Hand-written one-hot table for the sweep.
  localparam logic [7:0] EXP_HOT [8] = '{8'b00000001, 8'b00000010, 8'b00000100, 8'b00001000,
                                         8'b00010000, 8'b00100000, 8'b01000000, 8'b10000000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] yh, input logic [7:0] yl, input logic v);
    n_cmp++;
    if (y_h !== yh) begin n_bad++; $display("FAIL %s y(hi) got %b want %b", name, y_h, yh); end
    n_cmp++;
    if (y_l !== yl) begin n_bad++; $display("FAIL %s y(lo) got %b want %b", name, y_l, yl); end
    n_cmp++;
    if (v_h !== v || v_l !== v) begin
      n_bad++; $display("FAIL %s y_valid got %b/%b want %b", name, v_h, v_l, v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; e = 1'b1; a = 3'b101;
    tick(); chk("reset_edge1", 8'h00, 8'hFF, 1'b0);
    tick(); chk("reset_edge2", 8'h00, 8'hFF, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic test_disabled();
    e = 1'b0; a = 3'bxxx;
    tick(); chk("disabled_x", 8'h00, 8'hFF, 1'b0);
    a = 3'b111;
    tick(); chk("disabled_111", 8'h00, 8'hFF, 1'b0);
  endtask

  task automatic test_sweep();
    e = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      tick();
      chk($sformatf("sweep_a%0d", i), EXP_HOT[i], ~EXP_HOT[i], 1'b1);
    end
  endtask

  task automatic test_enable_drop();
    e = 1'b1; a = 3'b011;
    tick(); chk("endrop_on", 8'b00001000, 8'b11110111, 1'b1);
    e = 1'b0;
    tick(); chk("endrop_off", 8'b00000000, 8'b11111111, 1'b0);
  endtask

  task automatic test_reset_priority();
    e = 1'b1; a = 3'b110;
    tick(); chk("rstpri_pre", 8'b01000000, 8'b10111111, 1'b1);
    rst = 1'b1;
    tick(); chk("rstpri_rst", 8'b00000000, 8'b11111111, 1'b0);
    rst = 1'b0;
    tick(); chk("rstpri_post", 8'b01000000, 8'b10111111, 1'b1);
  endtask

  task automatic test_active_low();
    e = 1'b1; a = 3'b010;
    tick(); chk("actlow_on", 8'b00000100, 8'b11111011, 1'b1);
    e = 1'b0;
    tick(); chk("actlow_off", 8'b00000000, 8'b11111111, 1'b0);
  endtask

  task automatic test_hold();
    e = 1'b1; a = 3'b001;
    tick();
    a = 3'b100; #1; e = 1'b0; #1; a = 3'b111; #1;
    chk("hold_midcycle", 8'b00000010, 8'b11111101, 1'b1);
  endtask

  task automatic test_back_to_back();
    e = 1'b1; a = 3'b111;
    tick(); chk("b2b_7", 8'b10000000, 8'b01111111, 1'b1);
    a = 3'b000;
    tick(); chk("b2b_0", 8'b00000001, 8'b11111110, 1'b1);
    a = 3'b101;
    tick(); chk("b2b_5", 8'b00100000, 8'b11011111, 1'b1);
  endtask

  // Active-high output must never be multi-hot once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ($countones(y_h) > 1) begin
        n_bad++; $display("FAIL onehot popcount got %0d want <=1 (y=%b)", $countones(y_h), y_h);
      end
    end
  end

  initial begin
    test_reset();
    test_disabled();
    test_sweep();
    test_enable_drop();
    test_reset_priority();
    test_active_low();
    test_hold();
    test_back_to_back();
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decoder_3_to_8_bh.md
DECODER_3_TO_8_BH -- requirements
Module: decoder_3_to_8_bh

Interface
REQ-001 Parameter: OUT_ACTIVE_LOW, default 0, output polarity select (0 = selected line high, others low; 1 = selected line low, others high).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: a  input  3  binary select code, bit 2 = MSB.
REQ-005 Port: e  input  1  enable, active-high.
REQ-006 Port: y  output  8  decoded one-hot output, registered, y[0] corresponds to a=000.
REQ-007 Port: y_valid  output  1  registered flag, high when y holds a decode of an enabled input.
REQ-008 The block SHALL have one clock domain with no other clocks, no asynchronous inputs, and no latches.

Function
REQ-009 y and y_valid SHALL be driven directly from flip-flops updated only on the rising edge of clk.
REQ-010 Latency SHALL be exactly one cycle: values of a and e sampled at edge N appear on y and y_valid after edge N.
REQ-011 With OUT_ACTIVE_LOW=0 and e=1 at the edge, y SHALL become 8'b1 shifted left by a (a=000 gives 00000001; a=111 gives 10000000).
REQ-012 With OUT_ACTIVE_LOW=0 and e=0 at the edge, y SHALL become 8'h00 regardless of a, including when a is X or Z.
REQ-013 With OUT_ACTIVE_LOW=1, y SHALL be the bitwise inverse of the OUT_ACTIVE_LOW=0 value (e=0 gives 8'hFF).
REQ-014 y_valid SHALL equal the e value sampled at the same edge.
REQ-015 With OUT_ACTIVE_LOW=0, y SHALL have at most one bit set at all times, with no transient multi-hot register state.
REQ-016 A new a value SHALL be accepted every cycle, with no handshake and no backpressure.
REQ-017 The output SHALL hold its value between edges regardless of input activity.
REQ-018 If e is 1 but a contains X or Z, y SHALL be undefined and y_valid SHALL be 1; this case SHALL NOT be driven in verification.

Reset
REQ-019 When rst=1 at a rising edge, y SHALL take its inactive value (8'h00, or 8'hFF if OUT_ACTIVE_LOW=1) and y_valid SHALL become 0.
REQ-020 rst SHALL take priority over e and a at the same edge.
REQ-021 Asserting rst mid-stream SHALL discard the in-flight decode.
REQ-022 After deassertion, the first edge with rst=0 SHALL decode normally.
REQ-023 Before the first reset edge, output values SHALL be unspecified.

Verification
REQ-024 The bench SHALL cover reset: rst=1 for 2 edges with e=1, a=101, and expect y=00000000 and y_valid=0.
REQ-025 The bench SHALL cover disabled input: rst=0, e=0, a=XXX, and expect y=00000000 and y_valid=0 one cycle later.
REQ-026 The bench SHALL sweep all codes: e=1, a=000..111 one per cycle, and expect y=00000001, 00000010, ..., 10000000, each one cycle after its a, with y_valid=1.
REQ-027 The bench SHALL cover enable drop: e=1, a=011, then e=0 next cycle, and expect y=00001000 then 00000000, with y_valid going 1 then 0.
REQ-028 The bench SHALL cover reset priority: e=1, a=110 streaming with rst pulsed for 1 cycle, and expect y=00000000 after the reset edge and y=01000000 on the following edge.
REQ-029 The bench SHALL cover active-low polarity: OUT_ACTIVE_LOW=1, e=1, a=010, and expect y=11111011; with e=0, expect y=11111111.
REQ-030 The bench SHALL add a continuous check: with OUT_ACTIVE_LOW=0, the popcount of y is at most 1 on every cycle after reset.
